// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the 1280x1024@60 Hz raster generator.
// The default raster is 1688 clocks per line and 1066 lines per frame.
package vga_pkg;

    localparam int H_VISIBLE = 1280;
    localparam int H_FRONT   = 48;
    localparam int H_SYNC    = 112;
    localparam int H_BACK    = 248;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 1024;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 38;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int RGB_W = 24;
    localparam int CNT_W = 11;

    typedef logic [RGB_W-1:0] rgb24_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic valid;
    } sync_bus_t;

    // True when lo <= cnt < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
        return (int'(cnt) >= lo) && (int'(cnt) < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value.
// Exposes the last stage and the value that feeds it, so a sibling register can sit alongside the last stage.
module sync_delay_line #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= INIT;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // tap is what the last stage captures on the next edge.
    if (DEPTH == 1) begin : g_tap_din
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = stage_q[DEPTH-2];
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with coordinate/sync decode, plus an output stage that
// re-aligns sync/blank with the display pipeline's RGB and blacks out the non-visible area.
module vga_timing_gen #(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter bit SYNC_POL   = 1'b1,
    parameter int PIPE_DELAY = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [10:0]               x,
    output logic [9:0]                y,
    output logic                      valid,
    output logic                      vsync,
    output logic                      frame_start,
    input  logic [vga_pkg::RGB_W-1:0] rgb_in,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      blank_n_o,
    output logic [vga_pkg::RGB_W-1:0] rgb_o
);

    import vga_pkg::*;

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START    = H_VISIBLE + H_FRONT;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_VISIBLE + V_FRONT;
    localparam int VS_END      = VS_START + V_SYNC;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             running;
    logic             h_last;
    logic             v_last;

    assign h_last = (hcount == CNT_W'(LINE_TOTAL - 1));
    assign v_last = (vcount == CNT_W'(FRAME_TOTAL - 1));

    // The first edge after reset only arms the raster, so (0,0) is presented as a live pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount  <= '0;
            vcount  <= '0;
            running <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
        end else if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + CNT_W'(1);
        end else begin
            hcount <= hcount + CNT_W'(1);
        end
    end

    logic      hsync_act;
    logic      vsync_act;
    logic      hsync;
    sync_bus_t sync_now;
    sync_bus_t sync_tap;
    sync_bus_t sync_out;

    assign hsync_act = in_window(hcount, HS_START, HS_END);
    assign vsync_act = in_window(vcount, VS_START, VS_END);
    assign hsync     = SYNC_POL ? hsync_act : !hsync_act;

    assign x           = hcount;
    assign y           = vcount[9:0];
    assign valid       = running && in_window(hcount, 0, H_VISIBLE) && in_window(vcount, 0, V_VISIBLE);
    assign vsync       = SYNC_POL ? vsync_act : !vsync_act;
    assign frame_start = running && (hcount == '0) && (vcount == '0);

    assign sync_now = '{hsync: hsync, vsync: vsync, valid: valid};

    sync_delay_line #(
        .WIDTH ($bits(sync_bus_t)),
        .DEPTH (PIPE_DELAY),
        .INIT  ({!SYNC_POL, !SYNC_POL, 1'b0})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (sync_now),
        .tap   (sync_tap),
        .dout  (sync_out)
    );

    // RGB register shares the edge of the last delay stage so blank and colour flip together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_o <= '0;
        end else begin
            rgb_o <= sync_tap.valid ? rgb_in : '0;
        end
    end

    assign hsync_o   = sync_out.hsync;
    assign vsync_o   = sync_out.vsync;
    assign blank_n_o = sync_out.valid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size raster instance and a tiny-raster instance (PIPE_DELAY=1,
// negative sync) both checked every cycle against an absolute-cycle-index model of the raster.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        vsync;
        logic        frame_start;
        logic        hsync_o;
        logic        vsync_o;
        logic        blank_n_o;
        logic [23:0] rgb_o;
    } obs_t;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int d;  bit pol;
    } tim_t;

    localparam tim_t TM = '{hv: 1280, hf: 48, hs: 112, hb: 248, vv: 1024, vf: 1, vs: 3, vb: 38, d: 3, pol: 1'b1};
    localparam tim_t TS = '{hv: 16, hf: 2, hs: 3, hb: 4, vv: 8, vf: 1, vs: 2, vb: 2, d: 1, pol: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_m, rst_s;
    logic [10:0] x_m, x_s;
    logic [9:0]  y_m, y_s;
    logic        valid_m, valid_s, vsync_m, vsync_s, fs_m, fs_s;
    logic        hso_m, hso_s, vso_m, vso_s, bn_m, bn_s;
    logic [23:0] rgb_m, rgb_s, rgbo_m, rgbo_s;

    int          k_m, k_s;
    logic [23:0] prev_m, prev_s;

    vga_timing_gen u_dut (
        .clk (clk), .reset (rst_m), .x (x_m), .y (y_m), .valid (valid_m), .vsync (vsync_m),
        .frame_start (fs_m), .rgb_in (rgb_m), .hsync_o (hso_m), .vsync_o (vso_m),
        .blank_n_o (bn_m), .rgb_o (rgbo_m)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (3), .H_BACK (4),
        .V_VISIBLE (8), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .SYNC_POL (1'b0), .PIPE_DELAY (1)
    ) u_small (
        .clk (clk), .reset (rst_s), .x (x_s), .y (y_s), .valid (valid_s), .vsync (vsync_s),
        .frame_start (fs_s), .rgb_in (rgb_s), .hsync_o (hso_s), .vsync_o (vso_s),
        .blank_n_o (bn_s), .rgb_o (rgbo_s)
    );

    // Raster position of absolute cycle k, where k=0 is the first clock after reset release.
    function automatic int hpos(tim_t t, int k);
        return k % (t.hv + t.hf + t.hs + t.hb);
    endfunction

    function automatic int vpos(tim_t t, int k);
        return (k / (t.hv + t.hf + t.hs + t.hb)) % (t.vv + t.vf + t.vs + t.vb);
    endfunction

    function automatic logic [23:0] pattern(tim_t t, int k);
        logic [31:0] h, v;
        h = hpos(t, k);
        v = vpos(t, k);
        return {h[7:0], v[7:0], 8'hA5};
    endfunction

    // k<0 means "not yet running" (reset or before first edge); rgb_src is what blank_n_o should reveal.
    function automatic obs_t model(tim_t t, int k, logic [23:0] rgb_src);
        obs_t e;
        int   h, v, kd;
        e = '0;
        e.vsync   = !t.pol;
        e.hsync_o = !t.pol;
        e.vsync_o = !t.pol;
        if (k >= 0) begin
            h = hpos(t, k);
            v = vpos(t, k);
            e.x           = 11'(h);
            e.y           = 10'(v);
            e.valid       = (h < t.hv) && (v < t.vv);
            e.frame_start = (h == 0) && (v == 0);
            if (v >= t.vv + t.vf && v < t.vv + t.vf + t.vs) e.vsync = t.pol;
        end
        kd = k - t.d;
        if (kd >= 0) begin
            h = hpos(t, kd);
            v = vpos(t, kd);
            if (h >= t.hv + t.hf && h < t.hv + t.hf + t.hs) e.hsync_o = t.pol;
            if (v >= t.vv + t.vf && v < t.vv + t.vf + t.vs) e.vsync_o = t.pol;
            e.blank_n_o = (h < t.hv) && (v < t.vv);
            if (e.blank_n_o) e.rgb_o = rgb_src;
        end
        return e;
    endfunction

    // Value presented during cycle k is captured at the PIPE_DELAY-th edge after its pixel's x/y.
    function automatic logic [23:0] pick_rgb(tim_t t, int k, bit pat);
        if (pat && (k + 1 - t.d) >= 0) return pattern(t, k + 1 - t.d);
        return 24'($urandom);
    endfunction

    function automatic obs_t obs_main();
        return {x_m, y_m, valid_m, vsync_m, fs_m, hso_m, vso_m, bn_m, rgbo_m};
    endfunction

    function automatic obs_t obs_small();
        return {x_s, y_s, valid_s, vsync_s, fs_s, hso_s, vso_s, bn_s, rgbo_s};
    endfunction

    task automatic test_reset();
        obs_t e, o;
        rst_m = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rgb_m = 24'($urandom);
            e = model(TM, -1, 24'h0);
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset cyc=%0d got %h exp %h", i, o, e); end
        end
        rst_m = 1'b1;
        k_m   = -1;
        #1;
        e = model(TM, -1, 24'h0);
        o = obs_main();
        checks++;
        if (o !== e) begin errors++; $display("FAIL release got %h exp %h", o, e); end
        prev_m = pick_rgb(TM, k_m, 1'b1);
        rgb_m  = prev_m;
    endtask

    task automatic test_line_timing();
        obs_t e, o;
        int   nval = 0, nhs = 0, nfs = 0, first_hs = -1;
        for (int i = 0; i < 2 * 1688 + 8; i++) begin
            @(posedge clk); #1;
            k_m++;
            e = model(TM, k_m, pattern(TM, k_m - TM.d));
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL line_timing k=%0d got %h exp %h", k_m, o, e); end
            if (k_m < 1688) nval += int'(valid_m);
            if (k_m >= 3 && k_m < 1691 && hso_m === 1'b1) begin
                nhs++;
                if (first_hs < 0) first_hs = k_m - 3;
            end
            nfs += int'(fs_m);
            if (k_m == 1688) begin
                checks++;
                if (y_m !== 10'd1 || x_m !== 11'd0) begin
                    errors++; $display("FAIL y_wrap got x=%0d y=%0d exp x=0 y=1", x_m, y_m);
                end
            end
            if (k_m >= 3 && hpos(TM, k_m - 3) == 1280) begin
                checks++;
                if (rgbo_m !== 24'h0 || bn_m !== 1'b0) begin
                    errors++; $display("FAIL black_at_1280 got rgb=%h blank_n=%b exp 0", rgbo_m, bn_m);
                end
            end
            prev_m = pick_rgb(TM, k_m, 1'b1);
            rgb_m  = prev_m;
        end
        checks++;
        if (nval != 1280) begin errors++; $display("FAIL valid_count got %0d exp 1280", nval); end
        checks++;
        if (nhs != 112) begin errors++; $display("FAIL hsync_width got %0d exp 112", nhs); end
        checks++;
        if (first_hs != 1328) begin errors++; $display("FAIL hsync_start got %0d exp 1328", first_hs); end
        checks++;
        if (nfs != 1) begin errors++; $display("FAIL frame_start_count got %0d exp 1", nfs); end
    endtask

    task automatic test_rgb_random();
        obs_t e, o;
        for (int i = 0; i < 1700; i++) begin
            @(posedge clk); #1;
            k_m++;
            e = model(TM, k_m, prev_m);
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rgb_random k=%0d got %h exp %h", k_m, o, e); end
            prev_m = pick_rgb(TM, k_m, 1'b0);
            rgb_m  = prev_m;
        end
    endtask

    task automatic test_mid_line_reset();
        obs_t e, o;
        bit   found = 1'b0;
        for (int i = 0; i < 1700 && !found; i++) begin
            @(posedge clk); #1;
            k_m++;
            e = model(TM, k_m, prev_m);
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL pre_reset k=%0d got %h exp %h", k_m, o, e); end
            found  = (hpos(TM, k_m) == 600);
            prev_m = pick_rgb(TM, k_m, 1'b0);
            rgb_m  = prev_m;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_x600 got none exp x=600"); end
        rst_m = 1'b0;
        #1;
        e = model(TM, -1, 24'h0);
        o = obs_main();
        checks++;
        if (o !== e) begin errors++; $display("FAIL async_reset got %h exp %h", o, e); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_hold cyc=%0d got %h exp %h", i, o, e); end
        end
        rst_m  = 1'b1;
        k_m    = -1;
        prev_m = pick_rgb(TM, k_m, 1'b0);
        rgb_m  = prev_m;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            k_m++;
            e = model(TM, k_m, prev_m);
            o = obs_main();
            checks++;
            if (o !== e) begin errors++; $display("FAIL restart k=%0d got %h exp %h", k_m, o, e); end
            prev_m = pick_rgb(TM, k_m, 1'b0);
            rgb_m  = prev_m;
        end
    endtask

    task automatic test_small_frame();
        obs_t e, o;
        int   nval = 0, nvs = 0, nfs = 0, h;
        rst_s  = 1'b1;
        k_s    = -1;
        prev_s = 24'($urandom);
        rgb_s  = prev_s;
        for (int i = 0; i < 2 * 325 + 5; i++) begin
            @(posedge clk); #1;
            k_s++;
            e = model(TS, k_s, prev_s);
            o = obs_small();
            checks++;
            if (o !== e) begin errors++; $display("FAIL small_frame k=%0d got %h exp %h", k_s, o, e); end
            if (k_s < 325) begin
                nval += int'(valid_s);
                if (vsync_s === 1'b0) nvs++;
            end
            if (k_s < 650) nfs += int'(fs_s);
            h = hpos(TS, k_s);
            if (h == 18 || h == 22) begin
                checks++;
                if (hso_s !== 1'b1) begin errors++; $display("FAIL hsync_o_idle h=%0d got %b exp 1", h, hso_s); end
            end
            if (h == 19 || h == 21) begin
                checks++;
                if (hso_s !== 1'b0) begin errors++; $display("FAIL hsync_o_active h=%0d got %b exp 0", h, hso_s); end
            end
            if (k_s == 325) begin
                checks++;
                if (x_s !== 11'd0 || y_s !== 10'd0) begin
                    errors++; $display("FAIL frame_wrap got x=%0d y=%0d exp 0 0", x_s, y_s);
                end
            end
            prev_s = 24'($urandom);
            rgb_s  = prev_s;
        end
        checks++;
        if (nval != 128) begin errors++; $display("FAIL small_valid_count got %0d exp 128", nval); end
        checks++;
        if (nvs != 50) begin errors++; $display("FAIL small_vsync_count got %0d exp 50", nvs); end
        checks++;
        if (nfs != 2) begin errors++; $display("FAIL small_frame_start got %0d exp 2", nfs); end
    endtask

    task automatic test_small_mid_reset();
        obs_t e, o;
        bit   found = 1'b0;
        int   th, tv;
        th = int'($urandom_range(1, 15));
        tv = int'($urandom_range(1, 7));
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk); #1;
            k_s++;
            e = model(TS, k_s, prev_s);
            o = obs_small();
            checks++;
            if (o !== e) begin errors++; $display("FAIL small_pre_reset k=%0d got %h exp %h", k_s, o, e); end
            found  = (hpos(TS, k_s) == th) && (vpos(TS, k_s) == tv);
            prev_s = 24'($urandom);
            rgb_s  = prev_s;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL small_reach got none exp x=%0d y=%0d", th, tv); end
        rst_s = 1'b0;
        #1;
        e = model(TS, -1, 24'h0);
        o = obs_small();
        checks++;
        if (o !== e) begin errors++; $display("FAIL small_async_reset got %h exp %h", o, e); end
        @(posedge clk); #1;
        rst_s  = 1'b1;
        k_s    = -1;
        prev_s = 24'($urandom);
        rgb_s  = prev_s;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            k_s++;
            e = model(TS, k_s, prev_s);
            o = obs_small();
            checks++;
            if (o !== e) begin errors++; $display("FAIL small_restart k=%0d got %h exp %h", k_s, o, e); end
            prev_s = 24'($urandom);
            rgb_s  = prev_s;
        end
    endtask

    initial begin
        rst_m = 1'b0;
        rst_s = 1'b0;
        rgb_m = '0;
        rgb_s = '0;
        k_m   = -1;
        k_s   = -1;
        prev_m = '0;
        prev_s = '0;
        test_reset();
        test_line_timing();
        test_rgb_random();
        test_mid_line_reset();
        test_small_frame();
        test_small_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 1280x1024@60 Hz raster that drives wave_display_top.
- Produces pixel coordinates x/y, a visible-area valid flag and a vsync level, all from free-running horizontal and vertical counters.
- Also provides a downstream output stage. This stage delays hsync/vsync/blank by a fixed pipeline depth so they stay aligned with the registered RGB returned by the display pipeline, and it forces RGB to black outside the visible area.
- Sits between the 108 MHz pixel-clock domain root and the VGA/DVI pins.

Parameters:
- H_VISIBLE, 1280, visible pixels per line
- H_FRONT, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width (clocks)
- H_BACK, 248, horizontal back porch (clocks); line total is 1688
- V_VISIBLE, 1024, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BACK, 38, vertical back porch (lines); frame total is 1066
- SYNC_POL, 1, active level of hsync/vsync (1 = positive)
- PIPE_DELAY, 3, clocks from x/y/valid to rgb_in being valid (range 1..8)

Ports:
- clk  in  1  pixel clock, 108 MHz
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- x  out  11  current horizontal count, 0..1687
- y  out  10  current vertical count, 0..1065 (see wrap rule)
- valid  out  1  high when hcount<H_VISIBLE and vcount<V_VISIBLE
- vsync  out  1  undelayed vertical sync level, feeds wave_display_top
- frame_start  out  1  one-clock pulse when hcount=0 and vcount=0
- rgb_in  in  24  {r,g,b} from wave_display_top, PIPE_DELAY clocks behind x/y
- hsync_o  out  1  horizontal sync delayed by PIPE_DELAY
- vsync_o  out  1  vertical sync delayed by PIPE_DELAY
- blank_n_o  out  1  valid delayed by PIPE_DELAY
- rgb_o  out  24  registered rgb_in when blank_n_o=1, else 24'h0

Behaviour:
- Counters
  - hcount increments every clock and wraps from H_TOTAL-1 to 0.
  - vcount increments on that wrap and itself wraps from V_TOTAL-1 to 0.
  - Both counters are 11 bits internally; y is vcount[9:0].
  - Lines 1024..1065 are never valid, so the y aliasing in that range is harmless.
  - x, y and valid are registered outputs driven from the counter registers: zero extra latency relative to the counters.
- hsync is active (SYNC_POL) for H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 1328..1439.
- vsync is active for V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 1025..1027, over whole lines including hcount=0.
- frame_start is high for exactly one clock at (0,0) and never high while reset is asserted.
- Delay line
  - A shift register of depth PIPE_DELAY carries {hsync, vsync, valid}.
  - rgb_o is registered as rgb_in when stage PIPE_DELAY-1 of valid is 1, else 0. This register is the last stage, so rgb_o and blank_n_o change on the same edge.
- Reset (asynchronous, reset=0)
  - hcount=vcount=0.
  - x=0, y=0.
  - valid=0 while in reset.
  - vsync and hsync_o/vsync_o at the inactive level (!SYNC_POL).
  - blank_n_o=0, rgb_o=0, frame_start=0.
  - All delay-line stages are cleared to the inactive/0 values.
- First clock after reset release:
  - counters hold (0,0) and valid rises to 1;
  - frame_start pulses.
  - blank_n_o first rises PIPE_DELAY clocks later.
- Reset mid-frame: every output returns to its reset value immediately, with no partial-frame completion.
- Boundary cases:
  - hcount=1687 and vcount=1065 wraps to (0,0) in one clock.
  - hcount=1279 to 1280 drops valid the same cycle the count changes.
- No handshake exists: the block is free-running, and rgb_in is sampled blindly on the fixed PIPE_DELAY schedule.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_TOTAL=1688, V_TOTAL=1066, visible and porch values);
  - a localparam for sync start/end derived from them;
  - the rgb24 bus width (24).
- One natural sub-module, sync_delay_line: a parameterised shift register (WIDTH, DEPTH) with asynchronous active-low clear to a parameterised init value. It is used for the {hsync, vsync, valid} pipe.

Test Plan:
- Reset held 0 for 10 clocks, then released:
  - x=0, y=0, frame_start=1 on the first active clock;
  - blank_n_o=0 until clock 3, then 1;
  - rgb_o=0 during reset.
- Run 1688 clocks:
  - hsync active for exactly 112 clocks starting at x=1328;
  - valid high exactly for x=0..1279;
  - y increments 0 to 1 at the wrap.
- Run one full frame (1688*1066 clocks):
  - vsync active exactly on lines 1025..1027;
  - frame_start pulses once per frame;
  - exactly 1280*1024 valid cycles counted.
- Drive rgb_in = {x[7:0], y[7:0], 8'hA5} delayed 3 clocks:
  - rgb_o matches on every visible pixel;
  - rgb_o = 0 at delayed x=1280 and on line 1024.
- Assert reset at x=600, y=500:
  - all outputs reach reset values asynchronously before the next edge;
  - after release, counting restarts at (0,0).
- PIPE_DELAY=1 build: hsync_o trails hsync by exactly one clock, checked at x=1328 and x=1440.
